// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: stall encoding, NOP payload and the payload field layout
// used by every inter-stage register of the 5-stage core.
package cpu_pipe_pkg;

   localparam int   STALL_W    = 6;
   localparam logic Stop       = 1'b1;
   localparam logic NotStop    = 1'b0;

   localparam int   PAY_W      = 32 * 4;
   localparam logic [PAY_W-1:0] NOP_PAY = '0;
   localparam logic [7:0] ALU_NOP_OP = 8'h00;
   localparam logic [4:0] NOPRegAddr = 5'h00;

   typedef logic [STALL_W-1:0] stall_t;

   // Field offsets within the payload bus; unused upper bits stay zero
   localparam int PAY_WDATA_LSB = 0;
   localparam int PAY_WDATA_W   = 32;
   localparam int PAY_ADDR_LSB  = 32;
   localparam int PAY_ADDR_W    = 32;
   localparam int PAY_ALUOP_LSB = 64;
   localparam int PAY_ALUOP_W   = 8;
   localparam int PAY_WADDR_LSB = 72;
   localparam int PAY_WADDR_W   = 5;
   localparam int PAY_WE_BIT    = 77;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: payload + valid, stall-pair decode, exception flush,
// multi-cycle side-state loop-back and saturating bubble/hold counters.
module pipe_stage_reg #(
   parameter int PAY_W   = cpu_pipe_pkg::PAY_W,
   parameter int SIDE_W  = 66,
   parameter int DBG_W   = 32,
   parameter int STALL_W = cpu_pipe_pkg::STALL_W,
   parameter int UP_IDX  = 3,
   parameter int DN_IDX  = 4,
   parameter logic [PAY_W-1:0] NOP_PAY = '0,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [PAY_W-1:0]   in_pay,
   input  logic [SIDE_W-1:0]  in_side,
   input  logic [DBG_W-1:0]   in_dbg,
   output logic               out_valid,
   output logic [PAY_W-1:0]   out_pay,
   output logic [SIDE_W-1:0]  side_o,
   output logic [DBG_W-1:0]   out_dbg,
   output logic [CNT_W-1:0]   bub_cnt,
   output logic [CNT_W-1:0]   hold_cnt,
   output logic               stall_err
);
   import cpu_pipe_pkg::*;

   generate
      if (!((DN_IDX == UP_IDX + 1) && (DN_IDX < STALL_W))) begin : g_bad_idx
         $error("pipe_stage_reg: DN_IDX must equal UP_IDX+1 and lie inside the stall vector");
      end
   endgenerate

   logic               up;
   logic               dn;
   logic               valid_q, valid_d;
   logic [PAY_W-1:0]   pay_q,   pay_d;
   logic [SIDE_W-1:0]  side_q,  side_d;
   logic [DBG_W-1:0]   dbg_q,   dbg_d;
   logic               err_q,   err_d;
   logic               bub_inc;
   logic               hold_inc;

   assign up = (stall[UP_IDX] == Stop);
   assign dn = (stall[DN_IDX] == Stop);

   // Counters only move on real bubbles/holds; a flush cycle counts as neither
   assign bub_inc  = !flush && up && !dn;
   assign hold_inc = !flush && up && dn;

   always_comb begin
      valid_d = valid_q;
      pay_d   = pay_q;
      side_d  = side_q;
      dbg_d   = dbg_q;
      err_d   = err_q | (!up && dn);
      if (flush) begin
         valid_d = 1'b0;
         pay_d   = NOP_PAY;
         side_d  = '0;
         dbg_d   = '0;
      end else if (up && !dn) begin
         valid_d = 1'b0;
         pay_d   = NOP_PAY;
         side_d  = in_side;
         dbg_d   = in_dbg;
      end else if (!up) begin
         valid_d = in_valid;
         pay_d   = in_pay;
         side_d  = '0;
         dbg_d   = in_dbg;
      end else begin
         side_d  = in_side;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         pay_q   <= NOP_PAY;
         side_q  <= '0;
         dbg_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         pay_q   <= pay_d;
         side_q  <= side_d;
         dbg_q   <= dbg_d;
         err_q   <= err_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_bub_cnt (
      .clk (clk),
      .clr (rst),
      .inc (bub_inc),
      .cnt (bub_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
      .clk (clk),
      .clr (rst),
      .inc (hold_inc),
      .cnt (hold_cnt)
   );

   assign out_valid = valid_q;
   assign out_pay   = pay_q;
   assign side_o    = side_q;
   assign out_dbg   = dbg_q;
   assign stall_err = err_q;

endmodule
